// File: rtl/ultrasonic_pkg.sv
// Shared types, default parameters and mask helper for the multi-channel ultrasonic ranger.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_REPORT,
        S_NEXT
    } state_t;

    localparam int unsigned MAX_CH         = 16;
    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_CNT_W      = 16;
    localparam int unsigned DEF_PRESCALE   = 100;
    localparam int unsigned DEF_TRIG_TICKS = 10;

    // Returns {found, index} of the lowest set bit at or above 'from'.
    function automatic logic [4:0] next_set_bit(input logic [MAX_CH-1:0] mask,
                                                input int unsigned       from);
        logic [4:0] r;
        r = '0;
        for (int unsigned i = 0; i < MAX_CH; i++) begin
            if (!r[4] && (i >= from) && mask[i]) begin
                r = {1'b1, i[3:0]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ultrasonic_edge_sync.sv
// Two-flop synchroniser plus edge-detect register for one asynchronous echo input.
module ultrasonic_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo_async,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_async;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger_mc.sv
// Scans the masked sensor channels in ascending order: trigger, wait for echo, time it, report.
module ultrasonic_ranger_mc
    import ultrasonic_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned PRESCALE     = DEF_PRESCALE,
    parameter int unsigned TRIG_TICKS   = DEF_TRIG_TICKS,
    parameter int unsigned RISE_TIMEOUT = (1 << CNT_W) - 1,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic [NUM_CH-1:0] trig_out,
    input  logic [NUM_CH-1:0] echo_in,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [CNT_W-1:0]  res_value,
    output logic              res_timeout,
    output logic              done
);

    state_t            state_q, state_d;
    logic [CH_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0] mask_q;
    logic [31:0]       presc_q;
    logic [31:0]       tcnt_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] lvl, rise, fall;
    logic              tick, rise_sel, fall_sel;
    logic              mask_load, rep_load, rep_timeout, scan_end;
    logic [CNT_W-1:0]  rep_value;
    logic [4:0]        first_bit, next_bit;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
        ultrasonic_edge_sync u_sync (
            .clk        (clk),
            .rst        (rst),
            .echo_async (echo_in[g]),
            .level      (lvl[g]),
            .rise       (rise[g]),
            .fall       (fall[g])
        );
    end

    assign tick      = (presc_q == 32'(PRESCALE - 1));
    assign rise_sel  = rise[sel_q];
    assign fall_sel  = fall[sel_q];
    assign first_bit = next_set_bit(MAX_CH'(ch_mask), 0);
    assign next_bit  = next_set_bit(MAX_CH'(mask_q), 32'(sel_q) + 32'd1);
    assign res_valid = (state_q == S_REPORT);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        mask_load   = 1'b0;
        rep_load    = 1'b0;
        rep_value   = '0;
        rep_timeout = 1'b0;
        scan_end    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_load = 1'b1;
                    if (first_bit[4]) begin
                        sel_d   = CH_W'(first_bit[3:0]);
                        state_d = S_TRIG;
                    end else begin
                        scan_end = 1'b1;
                    end
                end
            end
            S_TRIG: begin
                if (tick && tcnt_q == 32'(TRIG_TICKS - 1)) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise_sel) begin
                    state_d = S_MEASURE;
                end else if (tick && tcnt_q == 32'(RISE_TIMEOUT - 1)) begin
                    state_d     = S_REPORT;
                    rep_load    = 1'b1;
                    rep_value   = '1;
                    rep_timeout = 1'b1;
                end
            end
            S_MEASURE: begin
                // A tick coinciding with the falling edge still belongs to the pulse.
                if (fall_sel) begin
                    state_d   = S_REPORT;
                    rep_load  = 1'b1;
                    rep_value = cnt_q + CNT_W'(tick);
                end else if (tick && cnt_q == {{(CNT_W-1){1'b1}}, 1'b0}) begin
                    state_d     = S_REPORT;
                    rep_load    = 1'b1;
                    rep_value   = '1;
                    rep_timeout = 1'b1;
                end
            end
            S_REPORT: begin
                if (res_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (next_bit[4]) begin
                    sel_d   = CH_W'(next_bit[3:0]);
                    state_d = S_TRIG;
                end else begin
                    state_d  = S_IDLE;
                    scan_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            mask_q      <= '0;
            presc_q     <= '0;
            tcnt_q      <= '0;
            cnt_q       <= '0;
            trig_out    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            res_ch      <= '0;
            res_value   <= '0;
            res_timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            if (mask_load) mask_q <= ch_mask;
            if (state_d != state_q) begin
                presc_q <= '0;
                tcnt_q  <= '0;
            end else if (tick) begin
                presc_q <= '0;
                tcnt_q  <= tcnt_q + 32'd1;
            end else begin
                presc_q <= presc_q + 32'd1;
            end
            if (state_q == S_WAIT_RISE) cnt_q <= '0;
            else if (state_q == S_MEASURE && tick) cnt_q <= cnt_q + 1'b1;
            trig_out <= (state_d == S_TRIG) ? (NUM_CH'(1) << sel_d) : '0;
            busy     <= (state_d != S_IDLE);
            done     <= scan_end;
            if (rep_load) begin
                res_ch      <= sel_q;
                res_value   <= rep_value;
                res_timeout <= rep_timeout;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger_mc.sv
// Directed bench for ultrasonic_ranger_mc with hand-computed expected results.
module tb_ultrasonic_ranger_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ch_mask;
    logic [3:0] trig_out;
    logic [3:0] echo_in;
    logic       busy;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_ch;
    logic [9:0] res_value;
    logic       res_timeout;
    logic       done;

    int n_checks = 0;
    int n_errors = 0;

    ultrasonic_ranger_mc #(
        .NUM_CH       (4),
        .CNT_W        (10),
        .PRESCALE     (4),
        .TRIG_TICKS   (2),
        .RISE_TIMEOUT (50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ch_mask     (ch_mask),
        .trig_out    (trig_out),
        .echo_in     (echo_in),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ch      (res_ch),
        .res_value   (res_value),
        .res_timeout (res_timeout),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_echo(input int ch, input int width);
        repeat (3) @(posedge clk);
        #1 echo_in[ch] = 1'b1;
        repeat (width) @(posedge clk);
        #1 echo_in[ch] = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] mask);
        @(posedge clk);
        #1 start = 1'b1; ch_mask = mask;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
    endtask

    // Call at a negedge; checks trigger shape, fires the echo, waits for the result.
    task automatic run_channel(input int ch, input int width, input logic [9:0] exp_val,
                               input logic exp_to, output int lat);
        int n;
        n = 0;
        while (trig_out[ch] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        check_val("trig_onehot", 32'(trig_out), 32'(1) << ch);
        check_val("trig_busy", 32'(busy), 1);
        n = 0;
        while (trig_out[ch] === 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_val("trig_len", n, 8);
        if (width > 0) begin
            fork
                pulse_echo(ch, width);
            join_none
        end
        lat = 0;
        while (res_valid !== 1'b1 && lat < 6000) begin @(negedge clk); lat++; end
        check_val("res_valid", 32'(res_valid), 1);
        check_val("res_ch", 32'(res_ch), ch);
        check_val("res_value", 32'(res_value), 32'(exp_val));
        check_val("res_timeout", 32'(res_timeout), 32'(exp_to));
    endtask

    // Call at the REPORT negedge with res_ready high and no further channels pending.
    task automatic done_seq();
        @(negedge clk);
        check_val("next_done", 32'(done), 0);
        check_val("next_busy", 32'(busy), 1);
        @(negedge clk);
        check_val("done_pulse", 32'(done), 1);
        check_val("done_busy", 32'(busy), 0);
        @(negedge clk);
        check_val("done_end", 32'(done), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_outs"},
                  {trig_out, busy, res_valid, res_ch, res_value, res_timeout, done}, 0);
    endtask

    initial begin
        int lat;
        int n;
        logic [3:0] trig_acc;
        logic busy_acc;
        logic done_acc;

        rst = 1'b1; start = 1'b0; ch_mask = '0; echo_in = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 rst = 1'b0;

        // Scenario 1: two channels, widths 40 and 80 cycles
        do_start(4'b0101);
        run_channel(0, 40, 10'd10, 1'b0, lat);
        run_channel(2, 80, 10'd20, 1'b0, lat);
        done_seq();

        // Scenario 2: rise timeout after 50 ticks
        do_start(4'b0010);
        run_channel(1, 0, 10'h3FF, 1'b1, lat);
        check_val("rise_timeout_lat", lat, 200);
        done_seq();

        // Scenario 3: saturation without wrap
        do_start(4'b0001);
        run_channel(0, 5000, 10'h3FF, 1'b1, lat);
        done_seq();
        n = 0;
        while (echo_in != 0 && n < 3000) begin @(negedge clk); n++; end
        check_val("echo_idle", 32'(echo_in), 0);
        repeat (5) @(negedge clk);

        // Scenario 4: consumer stall in REPORT
        res_ready = 1'b0;
        do_start(4'b0011);
        run_channel(0, 24, 10'd6, 1'b0, lat);
        trig_acc = '0;
        busy_acc = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_val("stall_valid", 32'(res_valid), 1);
            check_val("stall_fields", {res_ch, res_value, res_timeout}, {2'd0, 10'd6, 1'b0});
            trig_acc |= trig_out;
            busy_acc &= busy;
        end
        check_val("stall_trig", 32'(trig_acc), 0);
        check_val("stall_busy", 32'(busy_acc), 1);
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(negedge clk);
        check_val("accept_trig", 32'(trig_out), 0);
        @(negedge clk);
        check_val("post_accept_valid", 32'(res_valid), 0);
        check_val("post_accept_trig", 32'(trig_out), 0);
        @(negedge clk);
        check_val("next_ch_trig", 32'(trig_out), 32'b0010);
        run_channel(1, 12, 10'd3, 1'b0, lat);
        done_seq();

        // Scenario 5: empty mask, then a start ignored while busy
        @(posedge clk);
        #1 start = 1'b1; ch_mask = 4'b0000;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_val("empty_done", 32'(done), 1);
        check_val("empty_busy", 32'(busy), 0);
        check_val("empty_trig", 32'(trig_out), 0);
        @(negedge clk);
        check_val("empty_done_end", 32'(done), 0);
        do_start(4'b0001);
        run_channel(0, 8, 10'd2, 1'b0, lat);
        @(posedge clk);
        #1 start = 1'b1; ch_mask = 4'b1000;
        @(negedge clk);
        check_val("ign_busy", 32'(busy), 1);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_val("ign_done", 32'(done), 1);
        trig_acc = '0; busy_acc = 1'b0; done_acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            trig_acc |= trig_out;
            busy_acc |= busy;
            done_acc |= done;
        end
        check_val("ign_trig", 32'(trig_acc), 0);
        check_val("ign_busy_after", 32'(busy_acc), 0);
        check_val("ign_done_after", 32'(done_acc), 0);

        // Scenario 6: reset mid-MEASURE, then an immediate fresh scan
        do_start(4'b0100);
        n = 0;
        while (trig_out[2] === 1'b1 && n < 100) begin @(negedge clk); n++; end
        check_val("s6_trig_len", n, 8);
        fork
            pulse_echo(2, 400);
        join_none
        repeat (60) @(negedge clk);
        check_val("s6_mid_busy", 32'(busy), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; start = 1'b1; ch_mask = 4'b1000;
        @(negedge clk);
        check_all_zero("s6_reset");
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_val("s6_restart_trig", 32'(trig_out), 32'b1000);
        run_channel(3, 20, 10'd5, 1'b0, lat);
        done_seq();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ultrasonic_ranger_mc.md
ULTRASONIC_RANGER_MC -- requirements
Module: ultrasonic_ranger_mc

Interface
REQ-001 Parameters SHALL be as follows.
- NUM_CH, default 4: number of sensor channels, 1..16.
- CNT_W, default 16: width of the echo counter, 8..24.
- PRESCALE, default 100: clk cycles per count tick, at least 1.
- TRIG_TICKS, default 10: trigger pulse length in ticks, at least 1.
- RISE_TIMEOUT, default 2^CNT_W-1: maximum number of ticks to wait for the echo rising edge.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning).
- clk, in, 1: single clock for the whole block.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: single-cycle request to begin a scan.
- ch_mask, in, NUM_CH: channels to scan; sampled when start is accepted.
- trig_out, out, NUM_CH: registered per-channel trigger outputs.
- echo_in, in, NUM_CH: asynchronous echo inputs from the sensors.
- busy, out, 1: high from start acceptance until the done pulse.
- res_valid, out, 1: a result is presented on the result outputs.
- res_ready, in, 1: consumer accepts the presented result.
- res_ch, out, clog2(NUM_CH) (minimum 1): channel index of the result.
- res_value, out, CNT_W: echo width in ticks.
- res_timeout, out, 1: the result is a timeout or a saturation.
- done, out, 1: one-cycle pulse at the end of a scan.

Function
REQ-003 Each echo_in bit SHALL pass through a 2-flop synchroniser plus an edge-detect register, giving 3 cycles of input latency.
REQ-004 The tick prescaler SHALL:
- count 0..PRESCALE-1 and assert an internal tick on its terminal count;
- be cleared on every state entry, so the first tick occurs PRESCALE cycles after the transition.
REQ-005 The FSM SHALL have the states IDLE, TRIG, WAIT_RISE, MEASURE, REPORT and NEXT.
REQ-006 IDLE with start=1 SHALL:
- latch ch_mask;
- set busy on the next cycle;
- select the lowest set mask bit and go to TRIG.
REQ-007 IDLE with start=1 and ch_mask=0 SHALL pulse done one cycle later, without asserting busy or any trig_out bit.
REQ-008 start SHALL be ignored whenever busy=1.
REQ-009 In TRIG, only the selected trig_out bit SHALL be high, for exactly TRIG_TICKS*PRESCALE cycles; the FSM SHALL then go to WAIT_RISE.
REQ-010 WAIT_RISE SHALL:
- go to MEASURE on a synchronised rising edge, with the counter cleared;
- treat an echo that is already high on entry as no edge;
- after RISE_TIMEOUT ticks with no edge, go to REPORT with res_value all-ones and res_timeout=1.
REQ-011 MEASURE SHALL:
- add 1 to the counter per tick while echo is high;
- on a synchronised falling edge, go to REPORT with res_value equal to the count and res_timeout=0;
- if the count reaches all-ones, go to REPORT with res_value all-ones and res_timeout=1, with no wrap.
REQ-012 REPORT SHALL hold res_valid=1 with res_ch, res_value and res_timeout stable until res_valid and res_ready are both 1 in the same cycle.
REQ-013 The result SHALL be accepted in the cycle where res_valid and res_ready are both 1; res_valid SHALL deassert the following cycle and the FSM SHALL go to NEXT.
REQ-014 NEXT SHALL take one cycle and select the next higher set bit of the latched mask, then go to TRIG.
REQ-015 If no higher set bit remains, NEXT SHALL:
- pulse done for one cycle;
- clear busy in that same cycle;
- return to IDLE.
REQ-016 Echo edges on non-selected channels SHALL be ignored.
REQ-017 A falling edge in the same cycle as the saturation tick SHALL report the count with res_timeout=0.
REQ-018 Changes to ch_mask while busy SHALL have no effect.

Reset
REQ-019 With rst=1 at a clk edge, the block SHALL:
- force all outputs to 0;
- put the FSM in IDLE and clear the counter, the prescaler, the synchronisers and the latched mask.
REQ-020 Reset SHALL take effect in any state, mid-trigger or mid-report, with no result emitted and no done pulse.
REQ-021 The first start SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-022 Package ultrasonic_pkg SHALL hold:
- the FSM state type;
- the default parameter values;
- the function that finds the next set mask bit.
REQ-023 The synchroniser and edge detector SHALL be one sub-module, ultrasonic_edge_sync, instantiated NUM_CH times.
REQ-024 The RTL SHALL be 120-400 lines and synthesise for any legal parameter set.

Verification
REQ-025 The bench SHALL run these directed scenarios (all use NUM_CH=4, CNT_W=10, PRESCALE=4, TRIG_TICKS=2, RISE_TIMEOUT=50 unless stated):
- Scenario 1: start with mask=4'b0101; echo ch0 high for 40 cycles, ch2 high for 80 cycles; res_ready=1. Required: trig_out[0] high 8 cycles; results (ch0, 10, 0), then (ch2, 20, 0); then done.
- Scenario 2: mask=4'b0010, echo never rises. Required: result (ch1, 10'h3FF, timeout=1) after 50 ticks; then done.
- Scenario 3: echo held high 5000 cycles. Required: value 10'h3FF, timeout=1, counter does not wrap.
- Scenario 4: res_ready held low for 30 cycles during REPORT. Required: res_valid and the result fields stay stable; trig_out for the next channel does not start until 1 cycle after acceptance.
- Scenario 5: mask=0. Required: done one cycle after start, busy and trig_out stay 0. A second start while busy is ignored.
- Scenario 6: rst asserted mid-MEASURE. Required: all outputs 0 next cycle; a new start scans correctly.
